// File: rtl/tile_io_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tile_io_frontend                                              |
// | Desc     : Debounced, auto-repeating button pulses and per-array LED     |
// |            display modes (off/solid/blink/dim) with a win-flash override.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tile_io_frontend #(
  parameter int N_TILES         = 28,
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int BLINK_HALF      = 12500000,
  parameter int PWM_BITS        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_raw,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  input  logic [N_TILES-1:0]  tiles_p_in,
  input  logic [N_TILES-1:0]  tiles_g_in,
  input  logic [1:0]          mode_p,
  input  logic [1:0]          mode_g,
  input  logic [PWM_BITS-1:0] bright_p,
  input  logic [PWM_BITS-1:0] bright_g,
  input  logic                win,
  output logic [N_TILES-1:0]  led_p,
  output logic [N_TILES-1:0]  led_g,
  output logic                blink_phase
);

  localparam int C_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_RC_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int C_BK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [C_DB_W-1:0] r_db_cnt;
    logic [C_RC_W-1:0] r_rc;
    logic              r_level;
    logic              r_press;
    logic              w_diff;
    logic              w_accept;
    logic              w_rise;
    logic              w_fall;
    logic              w_rc_hit;
    logic [C_RC_W-1:0] w_rc_next;

    assign w_diff    = r_sync2[i] != r_level;
    assign w_accept  = w_diff && (r_db_cnt == C_DB_W'(DEBOUNCE_CYCLES - 1));
    assign w_rise    = w_accept && r_sync2[i];
    assign w_fall    = w_accept && !r_sync2[i];
    assign w_rc_next = r_rc + 1'b1;
    // The release edge itself never repeats, even if the repeat point lands on it
    assign w_rc_hit  = (REPEAT_DELAY > 0) && r_level && !w_fall &&
                       ((w_rc_next == C_RC_W'(REPEAT_DELAY)) ||
                        (w_rc_next == C_RC_W'(REPEAT_DELAY + REPEAT_RATE)));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_db_cnt <= '0;
        r_rc     <= '0;
        r_level  <= 1'b0;
        r_press  <= 1'b0;
      end else begin
        r_press <= w_rise | w_rc_hit;
        if (!w_diff) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_db_cnt <= '0;
          r_level  <= r_sync2[i];
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
        if (w_rise || w_fall || !r_level || (REPEAT_DELAY == 0)) begin
          r_rc <= '0;
        end else if (w_rc_next == C_RC_W'(REPEAT_DELAY + REPEAT_RATE)) begin
          r_rc <= C_RC_W'(REPEAT_DELAY);
        end else begin
          r_rc <= w_rc_next;
        end
      end
    end

    assign btn_level[i] = r_level;
    assign btn_press[i] = r_press;
  end

  logic [C_BK_W-1:0]   r_bk_cnt;
  logic                r_phase;
  logic                r_win_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_bk_wrap;
  logic                w_win_rise;
  logic                w_phase_next;

  assign w_bk_wrap    = r_bk_cnt == C_BK_W'(BLINK_HALF - 1);
  assign w_win_rise   = win && !r_win_q;
  // A fresh win restarts the blink so the flash begins lit
  assign w_phase_next = w_win_rise ? 1'b1 : (w_bk_wrap ? !r_phase : r_phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bk_cnt  <= '0;
      r_phase   <= 1'b0;
      r_win_q   <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      r_win_q   <= win;
      r_phase   <= w_phase_next;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_win_rise || w_bk_wrap) r_bk_cnt <= '0;
      else                         r_bk_cnt <= r_bk_cnt + 1'b1;
    end
  end

  function automatic logic f_enable(input logic [1:0] mode, input logic [PWM_BITS-1:0] bright,
                                    input logic phase, input logic [PWM_BITS-1:0] pwm);
    case (mode)
      2'b00:   f_enable = 1'b0;
      2'b01:   f_enable = 1'b1;
      2'b10:   f_enable = phase;
      default: f_enable = (&bright) ? 1'b1 : (pwm < bright);
    endcase
  endfunction

  logic                w_en_p;
  logic                w_en_g;
  logic [N_TILES-1:0]  r_led_p;
  logic [N_TILES-1:0]  r_led_g;

  assign w_en_p = f_enable(mode_p, bright_p, w_phase_next, r_pwm_cnt);
  assign w_en_g = f_enable(mode_g, bright_g, w_phase_next, r_pwm_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_p <= '0;
      r_led_g <= '0;
    end else if (win) begin
      r_led_p <= {N_TILES{w_phase_next}};
      r_led_g <= {N_TILES{w_phase_next}};
    end else begin
      r_led_p <= tiles_p_in & {N_TILES{w_en_p}};
      r_led_g <= tiles_g_in & {N_TILES{w_en_g}};
    end
  end

  assign led_p       = r_led_p;
  assign led_g       = r_led_g;
  assign blink_phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_tile_io_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tile_io_frontend                                           |
// | Desc     : Directed, table-driven self-checking bench for tile_io_frontend|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tile_io_frontend;

  localparam int C_NT = 28;
  localparam int C_NB = 5;
  localparam logic [C_NT-1:0] C_ONES = '1;

  logic            clk = 1'b0;
  logic            rst;
  logic [C_NB-1:0] btn_raw;
  logic [C_NB-1:0] btn_level;
  logic [C_NB-1:0] btn_press;
  logic [C_NT-1:0] tiles_p_in;
  logic [C_NT-1:0] tiles_g_in;
  logic [1:0]      mode_p;
  logic [1:0]      mode_g;
  logic [1:0]      bright_p;
  logic [1:0]      bright_g;
  logic            win;
  logic [C_NT-1:0] led_p;
  logic [C_NT-1:0] led_g;
  logic            blink_phase;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = !clk;

  tile_io_frontend #(
    .N_TILES(C_NT), .N_BTN(C_NB), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
    .REPEAT_RATE(8), .BLINK_HALF(10), .PWM_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level), .btn_press(btn_press),
    .tiles_p_in(tiles_p_in), .tiles_g_in(tiles_g_in), .mode_p(mode_p), .mode_g(mode_g),
    .bright_p(bright_p), .bright_g(bright_g), .win(win), .led_p(led_p), .led_g(led_g),
    .blink_phase(blink_phase)
  );

  typedef struct {
    string           name;
    logic [C_NT-1:0] tp, tg;
    logic [1:0]      mp, mg, bp, bg;
    logic [C_NT-1:0] ep, eg;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   hits;
    int   last_tog;
    int   ntog;
    logic prev_ph;
    logic seen;
    logic [7:0] smp;

    vecs[0] = '{"solid_p_off_g", 28'h0ABCDEF, 28'hFFFFFFF, 2'b01, 2'b00, 2'd0, 2'd0, 28'h0ABCDEF, 28'h0};
    vecs[1] = '{"off_p_solid_g", 28'h5555555, 28'hAAAAAAA, 2'b00, 2'b01, 2'd0, 2'd0, 28'h0, 28'hAAAAAAA};
    vecs[2] = '{"dim_full_dim_zero", 28'hFFFFFFF, 28'h0000001, 2'b11, 2'b11, 2'd3, 2'd0, 28'hFFFFFFF, 28'h0};
    vecs[3] = '{"solid_p_dim_full_g", 28'h8000001, 28'h1234567, 2'b01, 2'b11, 2'd0, 2'd3, 28'h8000001, 28'h1234567};
    vecs[4] = '{"solid_both", 28'h0, 28'hFFFFFFF, 2'b01, 2'b01, 2'd1, 2'd1, 28'h0, 28'hFFFFFFF};

    rst = 1'b1; btn_raw = '0; tiles_p_in = '0; tiles_g_in = '0;
    mode_p = 2'b00; mode_g = 2'b00; bright_p = '0; bright_g = '0; win = 1'b0;
    tick(); tick();
    chk("rst_led_p", 64'(led_p), 64'h0);
    chk("rst_led_g", 64'(led_g), 64'h0);
    chk("rst_btn_level", 64'(btn_level), 64'h0);
    chk("rst_btn_press", 64'(btn_press), 64'h0);
    chk("rst_blink_phase", 64'(blink_phase), 64'h0);
    rst = 1'b0;

    // Clean press on channel 0: accept exactly six edges after the raw change
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("t1_level_k%0d", k), 64'(btn_level[0]), 64'(k >= 6));
      chk($sformatf("t1_press_k%0d", k), 64'(btn_press[0]), 64'(k == 6));
    end
    btn_raw[0] = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      chk("t1_no_press_on_release", 64'(btn_press[0]), 64'h0);
      seen = !btn_level[0];
    end
    chk("t1_release_seen", 64'(seen), 64'h1);

    // Bounce shorter than the debounce window never reaches the outputs
    for (int k = 0; k < 18; k++) begin
      btn_raw[3] = (k < 8) ? !k[1] : 1'b0;
      tick();
      chk($sformatf("t2_level_k%0d", k), 64'(btn_level[3]), 64'h0);
      chk($sformatf("t2_press_k%0d", k), 64'(btn_press[3]), 64'h0);
    end

    // Held button on channel 2: accept pulse then auto-repeat
    btn_raw[2] = 1'b1;
    seen = 1'b0;
    hits = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (btn_level[2]) begin
        seen = 1'b1;
        hits = k;
      end
    end
    chk("t3_accept_seen", 64'(seen), 64'h1);
    chk("t3_accept_latency", 64'(hits), 64'd6);
    chk("t3_press_at_accept", 64'(btn_press[2]), 64'h1);
    for (int k = 1; k <= 70; k++) begin
      tick();
      chk($sformatf("t3_press_k%0d", k), 64'(btn_press[2]),
          64'(k == 20 || k == 28 || k == 36 || k == 44 || k == 52));
      chk($sformatf("t3_level_k%0d", k), 64'(btn_level[2]), 64'(k < 60));
      if (k == 54) btn_raw[2] = 1'b0;
    end

    // Reset mid-debounce discards progress; the button re-debounces from scratch
    btn_raw[1] = 1'b1;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("t7_rst_level", 64'(btn_level), 64'h0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("t7_level_k%0d", k), 64'(btn_level[1]), 64'(k == 6));
      chk($sformatf("t7_press_k%0d", k), 64'(btn_press[1]), 64'(k == 6));
    end
    btn_raw[1] = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // Static display modes
    foreach (vecs[i]) begin
      tiles_p_in = vecs[i].tp; tiles_g_in = vecs[i].tg;
      mode_p = vecs[i].mp; mode_g = vecs[i].mg;
      bright_p = vecs[i].bp; bright_g = vecs[i].bg;
      tick();
      chk({vecs[i].name, "_p"}, 64'(led_p), 64'(vecs[i].ep));
      chk({vecs[i].name, "_g"}, 64'(led_g), 64'(vecs[i].eg));
    end

    // Dim mode duty: bright=1 -> 1 of 4, bright=2 -> 2 of 4, bright=3 -> always
    tiles_g_in = C_ONES; mode_g = 2'b11; mode_p = 2'b00;
    for (int b = 1; b <= 3; b++) begin
      bright_g = 2'(b);
      tick();
      for (int k = 0; k < 8; k++) begin
        tick();
        chk($sformatf("t5_b%0d_allornone_k%0d", b, k), 64'(led_g == C_ONES || led_g == '0), 64'h1);
        smp[k] = (led_g == C_ONES);
      end
      chk($sformatf("t5_b%0d_win0", b), 64'(32'(smp[0]) + smp[1] + smp[2] + smp[3]), 64'(b == 3 ? 4 : b));
      chk($sformatf("t5_b%0d_win1", b), 64'(32'(smp[4]) + smp[5] + smp[6] + smp[7]), 64'(b == 3 ? 4 : b));
    end

    // Blink mode: led_p follows the phase, phase toggles every 10 cycles
    tiles_p_in = 28'h0000005; mode_p = 2'b10; mode_g = 2'b00;
    tick();
    prev_ph = blink_phase; last_tog = -1; ntog = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      chk($sformatf("t4_track_k%0d", k), 64'(led_p), blink_phase ? 64'h5 : 64'h0);
      if (blink_phase != prev_ph) begin
        if (last_tog >= 0) chk($sformatf("t4_half_period_k%0d", k), 64'(k - last_tog), 64'd10);
        last_tog = k;
        ntog++;
      end
      prev_ph = blink_phase;
    end
    chk("t4_toggle_count", 64'(ntog >= 4), 64'h1);

    // Win flash starts lit mid-blink, lasts one half-period
    tick(); tick(); tick();
    win = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("t6_led_p_k%0d", k), 64'(led_p), (k < 10) ? 64'(C_ONES) : 64'h0);
      chk($sformatf("t6_led_g_k%0d", k), 64'(led_g), (k < 10) ? 64'(C_ONES) : 64'h0);
    end
    rst = 1'b1;
    tick();
    chk("t6_rst_led_p", 64'(led_p), 64'h0);
    chk("t6_rst_led_g", 64'(led_g), 64'h0);
    chk("t6_rst_phase", 64'(blink_phase), 64'h0);
    rst = 1'b0; win = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
